// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues imem reads over a busywait handshake and feeds IF/ID
// from a small prefetch queue. Optional counters are built when IFU_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDRESS,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS_FOUR_OUT,
  output logic [31:0] INSTRUCTION_OUT,
  output logic        BUSYWAIT_OUT,
  output logic        FLUSH_OUT
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] BUBBLE_COUNT
`endif
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } q_entry_t;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             imem_read_q, imem_read_d;
  logic [31:0]      target_q, target_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  q_entry_t         queue_q [QUEUE_DEPTH];
  q_entry_t         queue_d [QUEUE_DEPTH];

  logic             resp;
  logic             outstanding_after;
  logic             queue_empty;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] occ_after;
  logic [31:0]      branch_tgt;
  q_entry_t         head;

  assign resp              = imem_read_q && !IMEM_BUSYWAIT;
  assign outstanding_after = imem_read_q && IMEM_BUSYWAIT;
  assign queue_empty       = (count_q == '0);
  assign branch_tgt        = BRANCH_TARGET & 32'hFFFF_FFFC;
  assign head              = queue_q[rd_ptr_q];

  // Next-state: redirect first, then drain completion, then normal push/pop/issue.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    imem_read_d = imem_read_q;
    target_d    = target_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    queue_d     = queue_q;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    occ_after   = count_q;

    if (BRANCH_TAKEN) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (outstanding_after) begin
        // Request must stay stable; remember where to go once it retires.
        state_d  = S_DRAIN;
        target_d = branch_tgt;
      end else begin
        state_d     = S_RUN;
        imem_read_d = 1'b1;
        req_addr_d  = branch_tgt;
        fetch_pc_d  = branch_tgt + 32'd4;
      end
    end else begin
      case (state_q)
        S_DRAIN: begin
          if (resp) begin
            state_d     = S_RUN;
            imem_read_d = 1'b1;
            req_addr_d  = target_q;
            fetch_pc_d  = target_q + 32'd4;
          end
        end
        S_IDLE, S_RUN: begin
          state_d = S_RUN;
          do_push = resp;
          do_pop  = !queue_empty && !STALL;
          if (do_push) begin
            queue_d[wr_ptr_q] = '{pc: req_addr_q, instr: IMEM_READDATA};
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
          end
          if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
          occ_after = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
          count_d   = occ_after;
          // A slot is reserved for every access, so only issue when one is free.
          if (!outstanding_after) begin
            if (occ_after < CNT_W'(QUEUE_DEPTH)) begin
              imem_read_d = 1'b1;
              req_addr_d  = fetch_pc_q;
              fetch_pc_d  = fetch_pc_q + 32'd4;
            end else begin
              imem_read_d = 1'b0;
            end
          end
        end
        default: begin
          state_d     = S_IDLE;
          imem_read_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= '0;
      imem_read_q <= 1'b0;
      target_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        queue_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      imem_read_q <= imem_read_d;
      target_q    <= target_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      queue_q     <= queue_d;
    end
  end

  assign IMEM_ADDRESS     = req_addr_q;
  assign IMEM_READ        = imem_read_q;
  assign FLUSH_OUT        = BRANCH_TAKEN;
  assign BUSYWAIT_OUT     = queue_empty;
  assign PC_OUT           = queue_empty ? 32'd0 : head.pc;
  assign PC_PLUS_FOUR_OUT = queue_empty ? 32'd0 : head.pc + 32'd4;
  assign INSTRUCTION_OUT  = queue_empty ? 32'd0 : head.instr;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  // Pushed responses and cycles where IF/ID starves while it could advance.
  always_comb begin
    fetch_count_d  = fetch_count_q + 32'(do_push);
    bubble_count_d = bubble_count_q + 32'(queue_empty && !STALL);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign FETCH_COUNT  = fetch_count_q;
  assign BUBBLE_COUNT = bubble_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vectors plus randomized stall/branch/wait traffic
// checked against a program-order reference model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_tgt = 32'h0;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_busy = 1'b0;
  logic [31:0] pc_out, pc4_out, instr_out;
  logic        busy_out, flush_out;

  logic [31:0] imem_addr2, imem_rdata2, pc2, pc42, instr2;
  logic        imem_read2, busy2, flush2;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt, fetch_cnt2, bubble_cnt2;
`endif

  instruction_fetch_unit u_dut (
`ifdef IFU_PERF_CNT_EN
    .FETCH_COUNT      (fetch_cnt),
    .BUBBLE_COUNT     (bubble_cnt),
`endif
    .CLK              (clk),
    .RESET            (rst),
    .STALL            (stall),
    .BRANCH_TAKEN     (br),
    .BRANCH_TARGET    (br_tgt),
    .IMEM_ADDRESS     (imem_addr),
    .IMEM_READ        (imem_read),
    .IMEM_READDATA    (imem_rdata),
    .IMEM_BUSYWAIT    (imem_busy),
    .PC_OUT           (pc_out),
    .PC_PLUS_FOUR_OUT (pc4_out),
    .INSTRUCTION_OUT  (instr_out),
    .BUSYWAIT_OUT     (busy_out),
    .FLUSH_OUT        (flush_out)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
`ifdef IFU_PERF_CNT_EN
    .FETCH_COUNT      (fetch_cnt2),
    .BUBBLE_COUNT     (bubble_cnt2),
`endif
    .CLK              (clk),
    .RESET            (rst),
    .STALL            (1'b0),
    .BRANCH_TAKEN     (1'b0),
    .BRANCH_TARGET    (32'h0),
    .IMEM_ADDRESS     (imem_addr2),
    .IMEM_READ        (imem_read2),
    .IMEM_READDATA    (imem_rdata2),
    .IMEM_BUSYWAIT    (1'b0),
    .PC_OUT           (pc2),
    .PC_PLUS_FOUR_OUT (pc42),
    .INSTRUCTION_OUT  (instr2),
    .BUSYWAIT_OUT     (busy2),
    .FLUSH_OUT        (flush2)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int captures = 0;

  // Memory model state
  int          wait_cycles = 0;
  bit          rand_wait = 1'b0;
  int          wcnt = 0;
  bit          in_acc = 1'b0;
  bit          new_req = 1'b0;
  bit          fixed_en = 1'b1;
  logic [31:0] fixed_val = 32'h0000_0013;

  // Reference model state: next PC IF/ID should capture, next address the fetcher should request
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_req = 32'h0;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_addr = 32'h0;

  function automatic logic [31:0] hash_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return fixed_en ? fixed_val : hash_word(a);
  endfunction

  assign imem_rdata2 = hash_word(imem_addr2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mem_update();
    new_req = 1'b0;
    if (!imem_read) begin
      in_acc     = 1'b0;
      imem_busy  = 1'b0;
      imem_rdata = 32'h0;
    end else begin
      if (!in_acc) begin
        in_acc  = 1'b1;
        new_req = 1'b1;
        wcnt    = rand_wait ? int'($urandom_range(3, 0)) : wait_cycles;
        chk("req_addr", imem_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end else if (wcnt > 0) begin
        wcnt--;
      end
      imem_busy  = (wcnt != 0);
      imem_rdata = imem_busy ? 32'hDEAD_BEEF : mem_word(imem_addr);
      if (!imem_busy) in_acc = 1'b0;
    end
  endtask

  task automatic monitor();
    if (rst) begin
      exp_pc    = 32'h0;
      exp_req   = 32'h0;
      hold_pend = 1'b0;
      return;
    end
    if (hold_pend) begin
      chk("req_stable_rd", 32'(imem_read), 32'd1);
      chk("req_stable_addr", imem_addr, hold_addr);
    end
    hold_pend = imem_read && imem_busy;
    hold_addr = imem_addr;
    chk("flush", 32'(flush_out), 32'(br));
    if (busy_out) begin
      chk("empty_pc", pc_out, 32'h0);
      chk("empty_pc4", pc4_out, 32'h0);
      chk("empty_instr", instr_out, 32'h0);
    end
    if (br) begin
      exp_pc  = br_tgt & 32'hFFFF_FFFC;
      exp_req = br_tgt & 32'hFFFF_FFFC;
    end else if (!busy_out && !stall) begin
      chk("cap_pc", pc_out, exp_pc);
      chk("cap_pc4", pc4_out, exp_pc + 32'd4);
      chk("cap_instr", instr_out, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      captures++;
    end
  endtask

  // One clock: check this cycle, cross the edge, answer the memory, settle.
  task automatic tick();
    #1;
    monitor();
    @(posedge clk);
    #1;
    mem_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] a, input int budget);
    int n = 0;
    while (!(imem_read && new_req && imem_addr == a) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_req_addr", imem_addr, a);
    chk("wait_req_new", 32'(imem_read && new_req), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (busy_out && n < budget) begin
      tick();
      n++;
    end
    chk("wait_valid", 32'(busy_out), 32'd0);
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        bsy;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ins;
    logic        rd2;
    logic [31:0] addr2;
    logic [31:0] pc2;
    logic [31:0] pc42;
  } row_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl [5];
    logic [31:0] held_pc;
    int cap0;

    // Cycles after reset release: main DUT (RESET_PC=0) and wrap DUT (RESET_PC=FFFFFFF8)
    tbl[0] = '{1'b0, 32'h0,  1'b1, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0,         32'h0,         32'h0};
    tbl[1] = '{1'b1, 32'h0,  1'b1, 32'h0, 32'h0, 32'h0,  1'b1, 32'hFFFF_FFF8, 32'h0,         32'h0};
    tbl[2] = '{1'b1, 32'h4,  1'b0, 32'h0, 32'h4, 32'h13, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    tbl[3] = '{1'b1, 32'h8,  1'b0, 32'h4, 32'h8, 32'h13, 1'b1, 32'h0,         32'hFFFF_FFFC, 32'h0};
    tbl[4] = '{1'b1, 32'hC,  1'b0, 32'h8, 32'hC, 32'h13, 1'b1, 32'h4,         32'h0,         32'h4};

    @(posedge clk);
    #2;

    // Zero-wait fetch after reset, including the wrapping reset PC
    fixed_en = 1'b1; fixed_val = 32'h0000_0013; wait_cycles = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("t1_read", 32'(imem_read), 32'(tbl[i].rd));
      if (tbl[i].rd) chk("t1_addr", imem_addr, tbl[i].addr);
      chk("t1_busy", 32'(busy_out), 32'(tbl[i].bsy));
      chk("t1_pc", pc_out, tbl[i].pc);
      chk("t1_pc4", pc4_out, tbl[i].pc4);
      chk("t1_instr", instr_out, tbl[i].ins);
      chk("t6_read", 32'(imem_read2), 32'(tbl[i].rd2));
      if (tbl[i].rd2) chk("t6_addr", imem_addr2, tbl[i].addr2);
      chk("t6_pc", pc2, tbl[i].pc2);
      chk("t6_pc4", pc42, tbl[i].pc42);
      tick();
    end

    // Three busywait cycles per access
    fixed_val = 32'h0050_0093; wait_cycles = 3;
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_read", 32'(imem_read), 32'd1);
      chk("t2_addr", imem_addr, 32'h0);
      chk("t2_busy", 32'(busy_out), 32'd1);
      tick();
    end
    chk("t2_busy_fall", 32'(busy_out), 32'd0);
    chk("t2_pc", pc_out, 32'h0);
    chk("t2_instr", instr_out, 32'h0050_0093);

    // Reset in the middle of an access
    do_reset();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_read", 32'(imem_read), 32'd0);
    chk("rst_mid_busy", 32'(busy_out), 32'd1);
    for (int i = 0; i < 12; i++) tick();

    // Downstream stall fills the queue and throttles requests
    fixed_en = 1'b0; wait_cycles = 0;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    stall = 1'b1;
    held_pc = pc_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_head", pc_out, held_pc);
      chk("t3_valid", 32'(busy_out), 32'd0);
      chk("t3_read", 32'(imem_read), 32'd0);
    end
    stall = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Redirect while the access to 0x8 still has busywait cycles left
    wait_cycles = 3;
    do_reset();
    wait_req(32'h8, 60);
    tick();
    br = 1'b1; br_tgt = 32'h0000_0102;
    #1;
    chk("t4_flush", 32'(flush_out), 32'd1);
    tick();
    br = 1'b0;
    for (int k = 0; k < 10 && imem_read && imem_addr == 32'h8; k++) tick();
    chk("t4_next_addr", imem_addr, 32'h100);
    chk("t4_next_read", 32'(imem_read), 32'd1);
    wait_valid(20);
    chk("t4_first_pc", pc_out, 32'h100);
    for (int i = 0; i < 8; i++) tick();

    // Second redirect during the drain wins
    do_reset();
    wait_req(32'h8, 60);
    br = 1'b1; br_tgt = 32'h100;
    #1;
    chk("t5_flush1", 32'(flush_out), 32'd1);
    tick();
    br_tgt = 32'h200;
    #1;
    chk("t5_flush2", 32'(flush_out), 32'd1);
    tick();
    br = 1'b0;
    for (int k = 0; k < 10 && imem_read && imem_addr == 32'h8; k++) tick();
    chk("t5_next_addr", imem_addr, 32'h200);
    wait_valid(20);
    chk("t5_first_pc", pc_out, 32'h200);
    for (int i = 0; i < 8; i++) tick();

    // Randomized stalls, redirects and memory latency
    rand_wait = 1'b1;
    do_reset();
    cap0 = captures;
    for (int i = 0; i < 3000; i++) begin
      stall  = ($urandom_range(99, 0) < 30);
      br     = ($urandom_range(99, 0) < 4);
      br_tgt = $urandom();
      tick();
    end
    stall = 1'b0;
    br = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rand_progress", 32'(captures - cap0 > 300), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
